// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART types: run-time framing configuration, receive FIFO entry layout
// and receiver state encoding, plus small helpers used by the receive path.
package uart_rx_oversampled_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic {
        STOP_1 = 1'b0,
        STOP_2 = 1'b1
    } stop_bits_t;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_t;

    typedef struct packed {
        logic [31:0] baud_rate;
        logic [3:0]  data_bits;
        parity_t     parity;
        stop_bits_t  stop_bits;
        bit_order_t  bit_order;
    } uart_config_t;

    typedef struct packed {
        logic       brk;
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_fifo_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_t;

    // Clocks per oversample tick; a zero baud or a too-fast baud collapses to 1.
    function automatic logic [31:0] calc_divisor(input logic [31:0] clk_freq,
                                                 input logic [31:0] baud,
                                                 input logic [31:0] oversample);
        logic [31:0] denom;
        logic [31:0] quot;
        denom = baud * oversample;
        quot  = (denom == 32'd0) ? 32'd1 : clk_freq / denom;
        return (quot == 32'd0) ? 32'd1 : quot;
    endfunction

    // Index of the last data bit; out-of-range widths are clamped to 5..8.
    function automatic logic [2:0] last_bit_idx(input logic [3:0] data_bits);
        logic [3:0] n;
        if (data_bits < 4'd5)
            n = 4'd5;
        else if (data_bits > 4'd8)
            n = 4'd8;
        else
            n = data_bits;
        return 3'(n - 4'd1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead FIFO with occupancy count; head is visible whenever valid.
// Push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_rd;
    logic             do_wr;

    assign valid = (count_reg != '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign do_rd = rd_en && valid;
    assign do_wr = wr_en && (!full || do_rd);
    assign count = count_reg;

    // Empty FIFO presents an all-zero head rather than stale storage.
    assign rd_data = valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: rx synchroniser, tick generator, majority-vote
// receive FSM with break detection, and a flagged receive FIFO with sticky overrun.
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int CLK_FREQ    = 1843200,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rx,
    input  uart_config_t                    uart_config,
    input  logic                            rd_en,
    input  logic                            clear_overrun,
    output logic                            rd_valid,
    output logic [7:0]                      rd_data,
    output logic                            rd_frame_err,
    output logic                            rd_parity_err,
    output logic                            rd_break,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overrun,
    output logic                            rx_busy
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] VOTE_IDX = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] LAST_IDX = SCW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;
    logic                   rx_prev_reg;
    logic [31:0]            divisor_reg;
    logic [31:0]            tick_cnt_reg;
    logic                   tick;
    logic                   start_accept;

    rx_state_t              state_reg;
    logic [SCW-1:0]         sample_cnt_reg;
    logic [SCW-1:0]         cnt_next;
    logic [1:0]             hist_reg;
    logic [2:0]             bit_idx_reg;
    logic [7:0]             data_reg;
    logic                   par_bit_reg;
    logic                   perr_reg;
    logic                   push_reg;
    rx_fifo_entry_t         push_entry_reg;
    logic                   overrun_reg;

    logic                   vote;
    logic                   vote_tick;
    logic                   end_tick;
    logic [2:0]             last_bit;
    logic [2:0]             data_pos;
    logic                   exp_par;

    rx_fifo_entry_t         head;
    logic                   fifo_full;
    logic                   unused_stop_bits;

    // Stop-bit count only matters to the transmitter.
    assign unused_stop_bits = uart_config.stop_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx};
            rx_prev_reg <= rx_s;
        end
    end

    assign rx_s         = sync_reg[SYNC_STAGES-1];
    assign start_accept = (state_reg == ST_IDLE) && rx_prev_reg && !rx_s;

    // Divisor is registered to keep the divide off the tick path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divisor_reg  <= 32'd1;
            tick_cnt_reg <= 32'd0;
        end else begin
            divisor_reg <= calc_divisor(32'(CLK_FREQ), uart_config.baud_rate, 32'(OVERSAMPLE));
            if (start_accept || tick)
                tick_cnt_reg <= 32'd0;
            else
                tick_cnt_reg <= tick_cnt_reg + 32'd1;
        end
    end

    // >= so a divisor shrinking mid-count cannot strand the counter.
    assign tick = (tick_cnt_reg >= divisor_reg - 32'd1);

    assign cnt_next  = (sample_cnt_reg >= LAST_IDX) ? '0 : sample_cnt_reg + SCW'(1);
    assign vote_tick = tick && (cnt_next == VOTE_IDX);
    assign end_tick  = tick && (cnt_next == '0);
    assign vote      = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s) | (hist_reg[0] & rx_s);
    assign last_bit  = last_bit_idx(uart_config.data_bits);
    assign data_pos  = (uart_config.bit_order == MSB_FIRST) ? last_bit - bit_idx_reg : bit_idx_reg;
    assign exp_par   = (uart_config.parity == PARITY_ODD) ? ~^data_reg : ^data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            sample_cnt_reg <= '0;
            hist_reg       <= 2'b11;
            bit_idx_reg    <= 3'd0;
            data_reg       <= 8'd0;
            par_bit_reg    <= 1'b0;
            perr_reg       <= 1'b0;
            push_reg       <= 1'b0;
            push_entry_reg <= '0;
        end else begin
            push_reg <= 1'b0;
            if (tick)
                hist_reg <= {hist_reg[0], rx_s};
            case (state_reg)
                ST_IDLE: begin
                    if (start_accept) begin
                        state_reg      <= ST_START;
                        sample_cnt_reg <= '0;
                        bit_idx_reg    <= 3'd0;
                        data_reg       <= 8'd0;
                        par_bit_reg    <= 1'b0;
                        perr_reg       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        sample_cnt_reg <= cnt_next;
                        if (vote_tick && vote)
                            state_reg <= ST_IDLE;
                        else if (end_tick)
                            state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        sample_cnt_reg <= cnt_next;
                        if (vote_tick)
                            data_reg[data_pos] <= vote;
                        if (end_tick) begin
                            if (bit_idx_reg >= last_bit) begin
                                bit_idx_reg <= 3'd0;
                                state_reg   <= (uart_config.parity == PARITY_NONE) ? ST_STOP : ST_PARITY;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        sample_cnt_reg <= cnt_next;
                        if (vote_tick) begin
                            par_bit_reg <= vote;
                            perr_reg    <= vote ^ exp_par;
                        end
                        if (end_tick)
                            state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        sample_cnt_reg <= cnt_next;
                        // Decide at the stop-bit centre so the next start edge can follow promptly.
                        if (vote_tick) begin
                            push_reg <= 1'b1;
                            if (data_reg == 8'd0 && !par_bit_reg && !vote) begin
                                push_entry_reg <= '{brk: 1'b1, perr: 1'b0, ferr: 1'b1, data: 8'd0};
                                sample_cnt_reg <= '0;
                                state_reg      <= ST_BREAK_WAIT;
                            end else begin
                                push_entry_reg <= '{brk: 1'b0, perr: perr_reg, ferr: !vote, data: data_reg};
                                state_reg      <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_BREAK_WAIT: begin
                    // Need a full bit time of continuous idle before re-arming.
                    if (tick) begin
                        if (!rx_s) begin
                            sample_cnt_reg <= '0;
                        end else begin
                            sample_cnt_reg <= cnt_next;
                            if (cnt_next == '0)
                                state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH ($bits(rx_fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_reg),
        .wr_data (push_entry_reg),
        .rd_en   (rd_en),
        .rd_data (head),
        .valid   (rd_valid),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // A dropped word wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n)
            overrun_reg <= 1'b0;
        else if (push_reg && fifo_full && !(rd_en && rd_valid))
            overrun_reg <= 1'b1;
        else if (clear_overrun)
            overrun_reg <= 1'b0;
    end

    assign rd_data       = head.data;
    assign rd_frame_err  = head.ferr;
    assign rd_parity_err = head.perr;
    assign rd_break      = head.brk;
    assign overrun       = overrun_reg;
    assign rx_busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: serialises frames onto rx and checks
// FIFO contents, flags, latency, overrun and reset behaviour.
module tb_uart_rx_oversampled;
    import uart_rx_oversampled_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx = 1'b1;
    logic         rd_en = 1'b0;
    logic         clear_overrun = 1'b0;
    uart_config_t cfg;
    logic         rd_valid;
    logic [7:0]   rd_data;
    logic         rd_frame_err;
    logic         rd_parity_err;
    logic         rd_break;
    logic [3:0]   fifo_count;
    logic         overrun;
    logic         rx_busy;

    int tests = 0;
    int fails = 0;
    int lat = 0;

    always #5 clk = ~clk;

    uart_rx_oversampled dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .uart_config   (cfg),
        .rd_en         (rd_en),
        .clear_overrun (clear_overrun),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_frame_err  (rd_frame_err),
        .rd_parity_err (rd_parity_err),
        .rd_break      (rd_break),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .rx_busy       (rx_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] d, input logic ferr,
                              input logic perr, input logic brk);
        check({tag, "_valid"}, 32'(rd_valid), 1);
        check({tag, "_data"}, 32'(rd_data), 32'(d));
        check({tag, "_ferr"}, 32'(rd_frame_err), 32'(ferr));
        check({tag, "_perr"}, 32'(rd_parity_err), 32'(perr));
        check({tag, "_brk"}, 32'(rd_break), 32'(brk));
    endtask

    task automatic set_cfg(input logic [31:0] baud, input logic [3:0] nb, input parity_t p,
                           input stop_bits_t s, input bit_order_t o);
        cfg.baud_rate = baud;
        cfg.data_bits = nb;
        cfg.parity    = p;
        cfg.stop_bits = s;
        cfg.bit_order = o;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!rd_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_arrive"}, 32'(rd_valid), 1);
    endtask

    // pmode 0 none / 1 even / 2 odd; glitch = frame bit index to corrupt for one tick mid-bit.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit msb, input int pmode,
                              input bit pflip, input bit stop_val, input int nstop, input int div,
                              input int glitch);
        logic [15:0] seq;
        logic        p;
        int          n;
        seq = '0;
        n = 1;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            seq[n] = msb ? d[nbits-1-i] : d[i];
            p = p ^ d[i];
            n++;
        end
        if (pmode == 1) begin
            seq[n] = p ^ pflip;
            n++;
        end else if (pmode == 2) begin
            seq[n] = ~p ^ pflip;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            seq[n] = stop_val;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            rx = seq[i];
            if (i == glitch) begin
                repeat (div * 8 - 6) @(negedge clk);
                rx = ~seq[i];
                repeat (div) @(negedge clk);
                rx = seq[i];
                repeat (div * 7 + 6) @(negedge clk);
            end else begin
                repeat (div * 16) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        cfg = '0;
        set_cfg(115200, 4'd8, PARITY_NONE, STOP_1, LSB_FIRST);
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(rx_busy), 0);
        check("rst_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 115200 8N1 LSB first, 0xA5, with latency from the start edge
        fork
            send_frame(8'hA5, 8, 1'b0, 0, 1'b0, 1'b1, 1, 1, -1);
            begin
                lat = 0;
                while (!rd_valid && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("a5_latency", 32'(lat), 157);
        check("a5_count", 32'(fifo_count), 1);
        check_head("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        pop();
        check("a5_popped", 32'(rd_valid), 0);

        // 9600 7E1 MSB first with a wrong parity bit
        set_cfg(9600, 4'd7, PARITY_EVEN, STOP_1, MSB_FIRST);
        send_frame(8'h5A, 7, 1'b1, 1, 1'b1, 1'b1, 1, 12, -1);
        wait_valid("7e1");
        check_head("7e1", 8'h5A, 1'b0, 1'b1, 1'b0);
        pop();

        // 9600 5O2, correct parity
        set_cfg(9600, 4'd5, PARITY_ODD, STOP_2, LSB_FIRST);
        send_frame(8'h15, 5, 1'b0, 2, 1'b0, 1'b1, 2, 12, -1);
        wait_valid("5o2");
        check_head("5o2", 8'h15, 1'b0, 1'b0, 1'b0);
        pop();

        // 4-clock start glitch must not produce a word
        set_cfg(9600, 4'd8, PARITY_NONE, STOP_1, LSB_FIRST);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy", 32'(rx_busy), 1);
        repeat (400) @(negedge clk);
        check("glitch_idle", 32'(rx_busy), 0);
        check("glitch_count", 32'(fifo_count), 0);

        // one-tick glitch in the middle of data bit 2 is voted out
        send_frame(8'h0F, 8, 1'b0, 0, 1'b0, 1'b1, 1, 12, 3);
        wait_valid("midglitch");
        check_head("midglitch", 8'h0F, 1'b0, 1'b0, 1'b0);
        pop();

        // stop bit low -> framing error, not break
        set_cfg(115200, 4'd8, PARITY_NONE, STOP_1, LSB_FIRST);
        send_frame(8'h33, 8, 1'b0, 0, 1'b0, 1'b0, 1, 1, -1);
        wait_valid("ferr");
        check_head("ferr", 8'h33, 1'b1, 1'b0, 1'b0);
        pop();
        repeat (20) @(negedge clk);

        // rx low for three frame times -> exactly one break entry
        rx = 1'b0;
        repeat (480) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("brk_count", 32'(fifo_count), 1);
        check_head("brk", 8'h00, 1'b1, 1'b0, 1'b1);
        check("brk_idle", 32'(rx_busy), 0);
        pop();
        check("brk_popped", 32'(fifo_count), 0);

        // FIFO_DEPTH+2 words without reads
        for (int i = 0; i < 10; i++) begin
            v = 8'h10 + 8'(i);
            send_frame(v, 8, 1'b0, 0, 1'b0, 1'b1, 1, 1, -1);
        end
        repeat (20) @(negedge clk);
        check("ovr_count", 32'(fifo_count), 8);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_head", 32'(rd_data), 32'h10);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);

        // pop in the exact cycle the next word is pushed while full
        fork
            send_frame(8'h5C, 8, 1'b0, 0, 1'b0, 1'b1, 1, 1, -1);
            begin
                repeat (156) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("pp_count", 32'(fifo_count), 8);
        check("pp_overrun", 32'(overrun), 0);
        check("pp_head", 32'(rd_data), 32'h11);

        for (int i = 0; i < 20 && rd_valid; i++)
            pop();
        check("drain_count", 32'(fifo_count), 0);

        // reset in the middle of a data bit with three words queued
        for (int i = 0; i < 3; i++) begin
            v = 8'hC0 + 8'(i);
            send_frame(v, 8, 1'b0, 0, 1'b0, 1'b1, 1, 1, -1);
        end
        repeat (10) @(negedge clk);
        check("pre_rst_count", 32'(fifo_count), 3);
        fork
            send_frame(8'hFF, 8, 1'b0, 0, 1'b0, 1'b1, 1, 1, -1);
            begin
                repeat (64) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_count", 32'(fifo_count), 0);
                check("mid_rst_valid", 32'(rd_valid), 0);
                check("mid_rst_busy", 32'(rx_busy), 0);
                check("mid_rst_overrun", 32'(overrun), 0);
            end
        join
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_count", 32'(fifo_count), 0);
        check("post_rst_busy", 32'(rx_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
